// File: rtl/key_event_encoder.sv
// key_event_encoder
//   Debounces the 16 raw key lines from the 4x4 keypad scanner, turns each
//   debounced edge into a press/release event tagged with the key index and
//   queues the events in a small first-word-fall-through FIFO.
//
// Ports
//   clk, rst_n      clock (posedge) and asynchronous active-low reset
//   key[15:0]       raw key state, 1 = pressed
//   sample_en       single-cycle qualifier; key is sampled only when high
//   ev_valid        head event present (FIFO non-empty)
//   ev_ready        consumer accepts head event
//   ev_code[3:0]    key index of head event (0 while empty)
//   ev_press        1 = press, 0 = release (0 while empty)
//   held[15:0]      debounced key state
//   fifo_count      number of stored events
//   overflow        sticky lost-event flag
//   clr_ovf         clears overflow (a simultaneous loss wins)
module key_event_encoder #(
  parameter int DB_CNT     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   key,
  input  logic                          sample_en,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [3:0]                    ev_code,
  output logic                          ev_press,
  output logic [15:0]                   held,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [7:0]    CNT_MAX = 8'(DB_CNT - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [15:0]   held_q, held_d;
  logic [15:0]   pend_q, pend_d;
  logic [15:0]   pdir_q, pdir_d;
  logic [7:0]    cnt_q [16];
  logic [7:0]    cnt_d [16];
  logic [4:0]    mem_q [FIFO_DEPTH];
  logic [4:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          pop, push, full, any_pend, lost;
  logic [3:0]    sel;

  always_comb begin
    held_d     = held_q;
    pend_d     = pend_q;
    pdir_d     = pdir_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    lost       = 1'b0;
    any_pend   = 1'b0;
    sel        = 4'd0;

    pop  = (count_q != '0) && ev_ready;
    full = (count_q == DEPTH_C);

    // Descending scan so the last hit is the lowest pending index.
    for (int i = 15; i >= 0; i--) begin
      if (pend_q[i]) begin
        any_pend = 1'b1;
        sel      = 4'(i);
      end
    end

    // A full FIFO can still take an event when the head leaves this cycle.
    push = any_pend && (!full || pop);

    if (push) begin
      pend_d[sel]      = 1'b0;
      mem_d[wr_ptr_q]  = {sel, pdir_q[sel]};
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Debounce runs after the push so a freshly completed toggle re-arms the
    // pend bit even if the previous event for that key leaves this cycle.
    if (sample_en) begin
      for (int i = 0; i < 16; i++) begin
        if (key[i] == held_q[i]) begin
          cnt_d[i] = 8'd0;
        end else if (cnt_q[i] == CNT_MAX) begin
          held_d[i] = ~held_q[i];
          cnt_d[i]  = 8'd0;
          if (pend_q[i] && !(push && (sel == 4'(i)))) begin
            lost = 1'b1;
          end
          pend_d[i] = 1'b1;
          pdir_d[i] = ~held_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end

    if (lost) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q     <= '0;
      pend_q     <= '0;
      pdir_q     <= '0;
      for (int i = 0; i < 16; i++) begin
        cnt_q[i] <= 8'd0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 5'd0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      held_q     <= held_d;
      pend_q     <= pend_d;
      pdir_q     <= pdir_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign ev_valid   = (count_q != '0);
  assign ev_code    = ev_valid ? mem_q[rd_ptr_q][4:1] : 4'd0;
  assign ev_press   = ev_valid ? mem_q[rd_ptr_q][0]   : 1'b0;
  assign held       = held_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_key_event_encoder.sv
module tb_key_event_encoder;

  logic        clk;
  logic        rst_n;
  logic [15:0] key;
  logic        sample_en;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_code;
  logic        ev_press;
  logic [15:0] held;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        clr_ovf;

  int checks   = 0;
  int failures = 0;

  key_event_encoder #(.DB_CNT(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .sample_en  (sample_en),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_press   (ev_press),
    .held       (held),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One qualified sample followed by three idle cycles (sample every 4th cycle).
  task automatic samp(input logic [15:0] k);
    key       = k;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    key       = 16'h0000;
    sample_en = 1'b0;
    ev_ready  = 1'b0;
    clr_ovf   = 1'b0;
    #12;
    chk("rst_valid", 32'(ev_valid), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    chk("rst_held", 32'(held), 32'h0);
    chk("rst_code", 32'(ev_code), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Clean press on key 5
    samp(16'h0020);
    samp(16'h0020);
    samp(16'h0020);
    chk("k5_pre_held", 32'(held), 32'h0);
    key       = 16'h0020;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    chk("k5_held", 32'(held), 32'h0020);
    chk("k5_not_yet_valid", 32'(ev_valid), 32'h0);
    tick();
    chk("k5_valid", 32'(ev_valid), 32'h1);
    chk("k5_code", 32'(ev_code), 32'h5);
    chk("k5_press", 32'(ev_press), 32'h1);
    chk("k5_count", 32'(fifo_count), 32'h1);
    tick();
    chk("k5_stable_code", 32'(ev_code), 32'h5);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    chk("k5_pop_count", 32'(fifo_count), 32'h0);
    chk("k5_pop_valid", 32'(ev_valid), 32'h0);
    chk("k5_empty_code", 32'(ev_code), 32'h0);

    // Bounce on key 2: 1,1,0,1,1,1,1
    samp(16'h0024);
    samp(16'h0024);
    samp(16'h0020);
    samp(16'h0024);
    samp(16'h0024);
    samp(16'h0024);
    chk("bnc_pre_held", 32'(held), 32'h0020);
    chk("bnc_pre_count", 32'(fifo_count), 32'h0);
    samp(16'h0024);
    chk("bnc_held", 32'(held), 32'h0024);
    chk("bnc_count", 32'(fifo_count), 32'h1);
    chk("bnc_code", 32'(ev_code), 32'h2);
    chk("bnc_press", 32'(ev_press), 32'h1);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    repeat (4) tick();
    chk("bnc_only_one", 32'(fifo_count), 32'h0);

    // Keys 3 and 9 finish on the same edge, consumer always ready
    ev_ready = 1'b1;
    samp(16'h022C);
    samp(16'h022C);
    samp(16'h022C);
    key       = 16'h022C;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    chk("dual_held", 32'(held), 32'h022C);
    tick();
    chk("dual_first_valid", 32'(ev_valid), 32'h1);
    chk("dual_first_code", 32'(ev_code), 32'h3);
    chk("dual_first_press", 32'(ev_press), 32'h1);
    tick();
    chk("dual_second_valid", 32'(ev_valid), 32'h1);
    chk("dual_second_code", 32'(ev_code), 32'h9);
    chk("dual_second_press", 32'(ev_press), 32'h1);
    tick();
    chk("dual_drained", 32'(fifo_count), 32'h0);

    // Release everything and drain (still ready)
    samp(16'h0000);
    samp(16'h0000);
    samp(16'h0000);
    samp(16'h0000);
    repeat (4) tick();
    chk("rel_held", 32'(held), 32'h0);
    chk("rel_drained", 32'(fifo_count), 32'h0);
    chk("rel_ovf", 32'(overflow), 32'h0);
    ev_ready = 1'b0;

    // Backpressure: keys 0..4 pressed together
    samp(16'h001F);
    samp(16'h001F);
    samp(16'h001F);
    samp(16'h001F);
    repeat (3) tick();
    chk("bp_count_sat", 32'(fifo_count), 32'h4);
    chk("bp_head_code", 32'(ev_code), 32'h0);
    chk("bp_head_press", 32'(ev_press), 32'h1);
    chk("bp_ovf", 32'(overflow), 32'h0);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    chk("bp_pop_push_count", 32'(fifo_count), 32'h4);
    chk("bp_new_head", 32'(ev_code), 32'h1);

    // Loss: key 7 press then release while press still pending
    samp(16'h009F);
    samp(16'h009F);
    samp(16'h009F);
    samp(16'h009F);
    chk("loss_press_held", 32'(held), 32'h009F);
    chk("loss_press_ovf", 32'(overflow), 32'h0);
    samp(16'h001F);
    samp(16'h001F);
    samp(16'h001F);
    samp(16'h001F);
    chk("loss_ovf", 32'(overflow), 32'h1);
    chk("loss_held", 32'(held), 32'h001F);
    chk("loss_count", 32'(fifo_count), 32'h4);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'h0);

    // Drain two: queue becomes 3, 4, 7(release)
    ev_ready = 1'b1;
    tick();
    tick();
    ev_ready = 1'b0;
    chk("pre_rst_count", 32'(fifo_count), 32'h3);
    chk("pre_rst_code", 32'(ev_code), 32'h3);
    tick();
    chk("pre_rst_tail_hold", 32'(fifo_count), 32'h3);

    // Key 8 completes, then reset before its event can be pushed
    samp(16'h011F);
    samp(16'h011F);
    samp(16'h011F);
    key       = 16'h011F;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    chk("pend_held", 32'(held), 32'h011F);
    chk("pend_count", 32'(fifo_count), 32'h3);
    rst_n = 1'b0;
    key   = 16'h0000;
    #1;
    chk("mid_rst_valid", 32'(ev_valid), 32'h0);
    chk("mid_rst_count", 32'(fifo_count), 32'h0);
    chk("mid_rst_held", 32'(held), 32'h0);
    tick();
    rst_n = 1'b1;
    samp(16'h0000);
    samp(16'h0000);
    samp(16'h0000);
    repeat (4) tick();
    chk("post_rst_valid", 32'(ev_valid), 32'h0);
    chk("post_rst_count", 32'(fifo_count), 32'h0);
    chk("post_rst_held", 32'(held), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_event_encoder.md
Name: key_event_encoder

Overview:
- Sits downstream of the 4x4 matrix keypad scanner.
- Consumes the scanner's raw 16-bit active-high key state and debounces each key independently.
- Converts each debounced state change into a press or release event with a key index.
- Buffers the events in a small FIFO that consumers read through a valid/ready handshake (display, password/calculator FSMs).

Parameters:
- DB_CNT, 16: number of consecutive qualified samples that must differ from the debounced state before that state toggles; legal range 2..255.
- FIFO_DEPTH, 4: event FIFO entries; must be a power of two, minimum 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset; asynchronous, active-low.
- key  input  16  raw key state from scanner, bit i = key i, 1 = pressed.
- sample_en  input  1  single-cycle qualifier; debounce logic samples key only when high.
- ev_valid  output  1  FIFO non-empty; head event presented.
- ev_ready  input  1  consumer accepts head event.
- ev_code  output  4  key index of head event.
- ev_press  output  1  1 = press, 0 = release (head event).
- held  output  16  debounced key state.
- fifo_count  output  log2(FIFO_DEPTH)+1  number of stored events.
- overflow  output  1  sticky: an event was lost.
- clr_ovf  input  1  clears overflow.

Behaviour:
- Reset (async, rst_n=0): held=0, all debounce counters=0, pending flags=0, FIFO empty, ev_valid=0, fifo_count=0, overflow=0. ev_code and ev_press read 0 while the FIFO is empty. Reset mid-operation discards all queued and pending events with no spurious event afterwards.
- Debounce, per key i, on posedge with sample_en=1:
  - key[i]==held[i]: cnt[i] is cleared to 0.
  - key[i]!=held[i] and cnt[i]<DB_CNT-1: cnt[i] increments.
  - key[i]!=held[i] and cnt[i]==DB_CNT-1: held[i] toggles, cnt[i]=0, pend[i]=1, pdir[i]=new held[i].
  - With sample_en=0, counters and held are unchanged. held therefore toggles on the DB_CNT-th consecutive differing sample.
- Re-toggle while pend[i]=1: pdir[i] is overwritten and overflow is set, so one event is lost. held always tracks the debounced state.
- Event issue, once per cycle:
  - Select the lowest index i with pend[i]=1 and push {i, pdir[i]} into the FIFO.
  - The push happens only if the FIFO is not full, or if it is full and a pop occurs in the same cycle. In that case pend[i] clears.
  - Otherwise pend[i] holds (stall) and is retried every cycle.
  - A pend bit set at edge E is pushed no earlier than edge E+1. ev_valid goes high after edge E+1 when the FIFO was empty and not stalled.
  - Latency from the qualifying sample_en edge to ev_valid is 1 cycle.
- FIFO:
  - First-word-fall-through.
  - ev_valid = (fifo_count != 0). A pop occurs at a posedge with ev_valid && ev_ready.
  - ev_code/ev_press stay stable while ev_valid=1 and ev_ready=0.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - ev_ready while empty has no effect.
- overflow: set on a lost event. Cleared on a posedge with clr_ovf=1, unless a set condition occurs in the same cycle, in which case set wins.
- Multiple keys completing debounce on the same edge each set their own pend bit. They drain in ascending index order, one per cycle.

Test Plan (DB_CNT=4, FIFO_DEPTH=4, sample_en every 4th cycle):
- Clean press, key[5]=1 for 4 samples:
  - held[5]=1 at the 4th sample edge; ev_valid next edge with ev_code=5, ev_press=1.
  - ev_ready=1 pops; fifo_count returns to 0.
- Bounce on key[2] (sample pattern 1,1,0,1,1,1,1):
  - No event until 4 consecutive 1s.
  - Exactly one press event, code 2; held[2]=1.
- Keys 9 and 3 complete debounce on the same edge with ev_ready=1:
  - Events are code 3 then code 9, in consecutive cycles, both with press=1.
- Backpressure, ev_ready=0, presses on keys 0,1,2,3,4:
  - fifo_count saturates at 4; key 4 stays pending and overflow stays 0.
  - One pop pushes code 4 in the same cycle; fifo_count stays 4.
- Loss case, FIFO full and ev_ready=0:
  - Key 7 press completes, then key 7 release completes while still pending: overflow=1, held[7]=0.
  - Assert clr_ovf: overflow=0 after the next edge.
- Reset mid-operation with 3 queued events and 1 pending:
  - rst_n=0 asynchronously gives ev_valid=0, fifo_count=0, held=0.
  - After release with key=0, no events appear.
